// File: rtl/dino_pkg.sv
// rtl/dino_pkg.sv - shared types and register map for the dino frame master
package dino_pkg;

  typedef enum logic [1:0] {
    POSE_RUN  = 2'd0,
    POSE_JUMP = 2'd1,
    POSE_DUCK = 2'd2
  } pose_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_BURST  = 2'd2
  } state_e;

  localparam logic [8:0] DINO_X_ADDR   = 9'd0;
  localparam logic [8:0] DINO_Y_ADDR   = 9'd1;
  localparam logic [8:0] JUMP_X_ADDR   = 9'd2;
  localparam logic [8:0] JUMP_Y_ADDR   = 9'd3;
  localparam logic [8:0] DUCK_X_ADDR   = 9'd4;
  localparam logic [8:0] DUCK_Y_ADDR   = 9'd5;
  localparam logic [8:0] CACTUS_X_ADDR = 9'd6;
  localparam logic [8:0] CACTUS_Y_ADDR = 9'd7;
  localparam logic [8:0] GODZ_X_ADDR   = 9'd8;
  localparam logic [8:0] GODZ_Y_ADDR   = 9'd9;

  localparam logic [3:0] LAST_BEAT = 4'd9;

  // Each pose owns a sprite slot; slots not matching the live pose are parked off-screen.
  function automatic logic [7:0] pose_coord(input pose_e pose, input pose_e slot,
                                            input logic [7:0] live, input logic [7:0] park);
    return (pose == slot) ? live : park;
  endfunction

endpackage

// File: rtl/dino_physics.sv
// rtl/dino_physics.sv - per-frame dino pose/velocity, cactus scroll and collision latch
module dino_physics
  import dino_pkg::*;
#(
  parameter logic [7:0] DINO_X       = 8'd40,
  parameter logic [7:0] GROUND_Y     = 8'd150,
  parameter logic [5:0] JUMP_V0      = 6'd12,
  parameter logic [5:0] GRAVITY      = 6'd1,
  parameter logic [7:0] SCROLL_STEP  = 8'd2,
  parameter logic [7:0] CACTUS_START = 8'd250
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       step_i,
  input  logic       jump_btn_i,
  input  logic       duck_btn_i,
  output logic [7:0] dino_y_o,
  output pose_e      pose_o,
  output logic [7:0] cactus_x_o,
  output logic       game_over_o
);

  logic [7:0]        dino_y_q, dino_y_d;
  logic signed [9:0] vel_q, vel_d;
  pose_e             pose_q, pose_d;
  logic [7:0]        cactus_x_q, cactus_x_d;
  logic              game_over_q, game_over_d;
  logic signed [9:0] y_calc;
  logic              hit;

  always_comb begin
    dino_y_d    = dino_y_q;
    vel_d       = vel_q;
    pose_d      = pose_q;
    cactus_x_d  = cactus_x_q;
    game_over_d = game_over_q;
    y_calc      = '0;
    hit         = 1'b0;
    if (step_i && !game_over_q) begin
      if (pose_q != POSE_JUMP) begin
        if (jump_btn_i) begin
          pose_d = POSE_JUMP;
          vel_d  = signed'({4'd0, JUMP_V0});
        end else if (duck_btn_i) begin
          pose_d = POSE_DUCK;
        end else begin
          pose_d = POSE_RUN;
        end
      end
      // Take-off frame already moves by JUMP_V0, so the apex lands V0 frames later.
      if (pose_d == POSE_JUMP) begin
        y_calc = signed'({2'b00, dino_y_q}) - vel_d;
        if (y_calc >= signed'({2'b00, GROUND_Y})) begin
          dino_y_d = GROUND_Y;
          vel_d    = '0;
          pose_d   = POSE_RUN;
        end else begin
          dino_y_d = y_calc[7:0];
          vel_d    = vel_d - signed'({4'd0, GRAVITY});
        end
      end
      cactus_x_d = (cactus_x_q < SCROLL_STEP) ? CACTUS_START : cactus_x_q - SCROLL_STEP;
      // 10-bit sums keep the +32 box edges from wrapping near the right border.
      hit = ({2'b00, cactus_x_d} < ({2'b00, DINO_X} + 10'd32)) &&
            (({2'b00, cactus_x_d} + 10'd32) > {2'b00, DINO_X}) &&
            (({2'b00, dino_y_d} + 10'd32) > {2'b00, GROUND_Y});
      game_over_d = hit;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dino_y_q    <= GROUND_Y;
      vel_q       <= '0;
      pose_q      <= POSE_RUN;
      cactus_x_q  <= CACTUS_START;
      game_over_q <= 1'b0;
    end else begin
      dino_y_q    <= dino_y_d;
      vel_q       <= vel_d;
      pose_q      <= pose_d;
      cactus_x_q  <= cactus_x_d;
      game_over_q <= game_over_d;
    end
  end

  assign dino_y_o    = dino_y_q;
  assign pose_o      = pose_q;
  assign cactus_x_o  = cactus_x_q;
  assign game_over_o = game_over_q;

endmodule

// File: rtl/dino_frame_master.sv
// rtl/dino_frame_master.sv - vsync-paced game update and 10-register sprite write burst
module dino_frame_master
  import dino_pkg::*;
#(
  parameter logic [7:0] DINO_X       = 8'd40,
  parameter logic [7:0] GROUND_Y     = 8'd150,
  parameter logic [5:0] JUMP_V0      = 6'd12,
  parameter logic [5:0] GRAVITY      = 6'd1,
  parameter logic [7:0] SCROLL_STEP  = 8'd2,
  parameter logic [7:0] CACTUS_START = 8'd250,
  parameter logic [7:0] PARK_X       = 8'd250,
  parameter logic [7:0] PARK_Y       = 8'd0,
  parameter logic [7:0] GODZ_X       = 8'd100,
  parameter logic [7:0] GODZ_Y       = 8'd200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        vga_vs,
  input  logic        jump_btn,
  input  logic        duck_btn,
  output logic        chipselect,
  output logic        write,
  output logic [8:0]  address,
  output logic [31:0] writedata,
  output logic        busy,
  output logic        game_over
);

  state_e     state_q, state_d;
  logic [3:0] beat_q, beat_d;
  logic       vs_prev_q;
  logic       tick;
  logic       step;
  logic [7:0] dino_y;
  pose_e      pose;
  logic [7:0] cactus_x;
  logic [7:0] payload;

  // vga_vs is already in the clk domain; a falling edge marks a new frame.
  assign tick = enable && !vga_vs && vs_prev_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      vs_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      vs_prev_q <= vga_vs;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (tick) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        state_d = ST_BURST;
        beat_d  = '0;
      end
      ST_BURST: begin
        if (beat_q == LAST_BEAT) begin
          state_d = ST_IDLE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_comb begin
    chipselect = 1'b0;
    write      = 1'b0;
    busy       = 1'b0;
    step       = 1'b0;
    address    = '0;
    writedata  = '0;
    case (state_q)
      ST_UPDATE: step = 1'b1;
      ST_BURST: begin
        chipselect = 1'b1;
        write      = 1'b1;
        busy       = 1'b1;
        address    = {5'd0, beat_q};
        writedata  = {24'd0, payload};
      end
      default: ;
    endcase
  end

  always_comb begin
    payload = 8'd0;
    case ({5'd0, beat_q})
      DINO_X_ADDR:   payload = pose_coord(pose, POSE_RUN,  DINO_X, PARK_X);
      DINO_Y_ADDR:   payload = pose_coord(pose, POSE_RUN,  dino_y, PARK_Y);
      JUMP_X_ADDR:   payload = pose_coord(pose, POSE_JUMP, DINO_X, PARK_X);
      JUMP_Y_ADDR:   payload = pose_coord(pose, POSE_JUMP, dino_y, PARK_Y);
      DUCK_X_ADDR:   payload = pose_coord(pose, POSE_DUCK, DINO_X, PARK_X);
      DUCK_Y_ADDR:   payload = pose_coord(pose, POSE_DUCK, dino_y, PARK_Y);
      CACTUS_X_ADDR: payload = cactus_x;
      CACTUS_Y_ADDR: payload = GROUND_Y;
      GODZ_X_ADDR:   payload = GODZ_X;
      GODZ_Y_ADDR:   payload = GODZ_Y;
      default:       payload = 8'd0;
    endcase
  end

  dino_physics #(
    .DINO_X       (DINO_X),
    .GROUND_Y     (GROUND_Y),
    .JUMP_V0      (JUMP_V0),
    .GRAVITY      (GRAVITY),
    .SCROLL_STEP  (SCROLL_STEP),
    .CACTUS_START (CACTUS_START)
  ) u_physics (
    .clk         (clk),
    .reset_n     (reset_n),
    .step_i      (step),
    .jump_btn_i  (jump_btn),
    .duck_btn_i  (duck_btn),
    .dino_y_o    (dino_y),
    .pose_o      (pose),
    .cactus_x_o  (cactus_x),
    .game_over_o (game_over)
  );

endmodule

// File: tb/tb_dino_frame_master.sv
// tb/tb_dino_frame_master.sv - directed bench with a frame-level behavioural model
module tb_dino_frame_master;

  logic        clk = 1'b0;
  logic        reset_n, enable, vga_vs, jump_btn, duck_btn;
  logic        chipselect, write, busy, game_over;
  logic [8:0]  address;
  logic [31:0] writedata;
  logic        cs2, wr2, busy2, go2;
  logic [8:0]  addr2;
  logic [31:0] wd2;

  always #5 clk = ~clk;

  dino_frame_master dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .vga_vs(vga_vs),
    .jump_btn(jump_btn), .duck_btn(duck_btn),
    .chipselect(chipselect), .write(write), .address(address),
    .writedata(writedata), .busy(busy), .game_over(game_over)
  );

  // A scroll step of 125 makes the cactus jump over the dino box, so the wrap is reachable.
  dino_frame_master #(.SCROLL_STEP(8'd125)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .enable(enable), .vga_vs(vga_vs),
    .jump_btn(jump_btn), .duck_btn(duck_btn),
    .chipselect(cs2), .write(wr2), .address(addr2),
    .writedata(wd2), .busy(busy2), .game_over(go2)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int m_age = -1;
  bit m_vs_prev = 1'b1;
  int m_y = 150, m_vel = 0, m_pose = 0, m_cx = 250;
  bit m_go = 1'b0;
  bit m_valid = 1'b0;
  bit e_cs = 1'b0, e_go = 1'b0;
  int e_addr = 0, e_wd = 0;

  int nbeats = 0;
  int val[10];
  int first_cyc = 0, last_cyc = 0, tick_cyc = 0;
  int cx2_last = -1;
  int b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_payload(input int a);
    case (a)
      0: return (m_pose == 0) ? 40 : 250;
      1: return (m_pose == 0) ? m_y : 0;
      2: return (m_pose == 1) ? 40 : 250;
      3: return (m_pose == 1) ? m_y : 0;
      4: return (m_pose == 2) ? 40 : 250;
      5: return (m_pose == 2) ? m_y : 0;
      6: return m_cx;
      7: return 150;
      8: return 100;
      default: return 200;
    endcase
  endfunction

  task automatic model_frame(input bit jb, input bit db);
    int ny;
    if (m_go) return;
    if (m_pose != 1) begin
      if (jb) begin m_pose = 1; m_vel = 12; end
      else if (db) m_pose = 2;
      else m_pose = 0;
    end
    if (m_pose == 1) begin
      ny = m_y - m_vel;
      if (ny >= 150) begin m_y = 150; m_vel = 0; m_pose = 0; end
      else begin m_y = ny; m_vel = m_vel - 1; end
    end
    m_cx = (m_cx < 2) ? 250 : m_cx - 2;
    if (m_cx < 72 && m_cx + 32 > 40 && m_y + 32 > 150) m_go = 1'b1;
  endtask

  task automatic observe();
    bit tick;
    if (m_valid) begin
      total++;
      if (chipselect !== e_cs || write !== e_cs || busy !== e_cs || game_over !== e_go ||
          address !== 9'(e_addr) || writedata !== 32'(e_wd)) begin
        bad++;
        $display("FAIL bus cyc=%0d got cs=%b wr=%b busy=%b go=%b addr=%0d data=%0d want cs=%b go=%b addr=%0d data=%0d",
                 cyc, chipselect, write, busy, game_over, address, writedata, e_cs, e_go, e_addr, e_wd);
      end
    end
    if (chipselect === 1'b1 && address < 9'd10) begin
      nbeats++;
      val[int'(address)] = int'(writedata[7:0]);
      if (address == 9'd0) first_cyc = cyc;
      if (address == 9'd9) last_cyc = cyc;
    end
    if (cs2 === 1'b1 && addr2 == 9'd6) cx2_last = int'(wd2[7:0]);
    if (!reset_n) begin
      m_age = -1; m_vs_prev = 1'b1; m_y = 150; m_vel = 0; m_pose = 0; m_cx = 250;
      m_go = 1'b0; m_valid = 1'b1;
    end else begin
      tick = enable && !vga_vs && m_vs_prev;
      m_vs_prev = vga_vs;
      if (m_age == -1) m_age = tick ? 1 : -1;
      else if (m_age == 1) begin model_frame(jump_btn, duck_btn); m_age = 2; end
      else if (m_age == 11) m_age = -1;
      else m_age = m_age + 1;
    end
    e_cs   = (m_age >= 2);
    e_addr = e_cs ? m_age - 2 : 0;
    e_wd   = e_cs ? model_payload(e_addr) : 0;
    e_go   = m_go;
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic run_frame(input bit jb, input bit db);
    jump_btn = jb;
    duck_btn = db;
    vga_vs   = 1'b0;
    tick_cyc = cyc;
    steps(3);
    vga_vs = 1'b1;
    steps(12);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; enable = 1'b1; vga_vs = 1'b1; jump_btn = 1'b0; duck_btn = 1'b0;
    steps(2);
    reset_n = 1'b1;
    steps(2);
  endtask

  initial begin
    int exp0[10];
    exp0 = '{40, 150, 250, 0, 250, 0, 248, 150, 100, 200};
    reset_n = 1'b0; enable = 1'b1; vga_vs = 1'b1; jump_btn = 1'b0; duck_btn = 1'b0;

    do_reset();
    check("reset_cs", int'(chipselect), 0);
    check("reset_addr", int'(address), 0);
    check("reset_data", int'(writedata), 0);
    check("reset_go", int'(game_over), 0);

    b0 = nbeats;
    run_frame(1'b0, 1'b0);
    check("f1_beats", nbeats - b0, 10);
    check("f1_first_lat", first_cyc - tick_cyc, 2);
    check("f1_last_lat", last_cyc - tick_cyc, 11);
    for (int i = 0; i < 10; i++) check($sformatf("f1_addr%0d", i), val[i], exp0[i]);
    check("wrap_f1", cx2_last, 125);

    for (int f = 2; f <= 91; f++) begin
      run_frame(1'b0, 1'b0);
      if (f == 2) check("wrap_f2", cx2_last, 0);
      if (f == 3) begin
        check("wrap_f3", cx2_last, 250);
        check("wrap_no_hit", int'(go2), 0);
      end
      if (f == 89) begin
        check("f89_cx", val[6], 72);
        check("f89_go", int'(game_over), 0);
      end
      if (f == 90) begin
        check("f90_cx", val[6], 70);
        check("f90_go", int'(game_over), 1);
      end
      if (f == 91) begin
        check("f91_frozen_cx", val[6], 70);
        check("f91_dino_y", val[1], 150);
      end
    end
    enable = 1'b0;
    b0 = nbeats;
    run_frame(1'b0, 1'b0);
    check("enable_low_beats", nbeats - b0, 0);
    enable = 1'b1;

    do_reset();
    run_frame(1'b1, 1'b0);
    check("jump_f1_y", val[3], 138);
    check("jump_f1_x", val[2], 40);
    check("jump_f1_run_park", val[0], 250);
    for (int f = 2; f <= 25; f++) begin
      run_frame(1'b0, 1'b0);
      if (f == 2) check("jump_f2_y", val[3], 127);
      if (f == 12) check("jump_peak_y", val[3], 72);
      if (f == 24) check("jump_f24_y", val[3], 138);
      if (f == 25) begin
        check("land_run_y", val[1], 150);
        check("land_run_x", val[0], 40);
        check("land_jump_park", val[3], 0);
      end
    end

    do_reset();
    run_frame(1'b1, 1'b1);
    check("both_jump_x", val[2], 40);
    check("both_jump_y", val[3], 138);
    check("both_duck_park", val[4], 250);

    do_reset();
    run_frame(1'b0, 1'b1);
    check("duck_x", val[4], 40);
    check("duck_y", val[5], 150);
    check("duck_run_x_park", val[0], 250);
    check("duck_run_y_park", val[1], 0);
    run_frame(1'b0, 1'b0);
    check("unduck_run_x", val[0], 40);

    do_reset();
    b0 = nbeats;
    vga_vs = 1'b0;
    steps(5);
    vga_vs = 1'b1;
    steps(1);
    vga_vs = 1'b0;
    steps(14);
    vga_vs = 1'b1;
    steps(5);
    check("drop_beats", nbeats - b0, 10);
    check("drop_single_update", val[6], 248);

    do_reset();
    run_frame(1'b1, 1'b0);
    b0 = nbeats;
    vga_vs = 1'b0;
    steps(3);
    vga_vs = 1'b1;
    steps(3);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    steps(10);
    check("abort_beats", nbeats - b0, 5);
    b0 = nbeats;
    run_frame(1'b0, 1'b0);
    check("fresh_beats", nbeats - b0, 10);
    for (int i = 0; i < 10; i++) check($sformatf("fresh_addr%0d", i), val[i], exp0[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
